// File: rtl/task_10_frame_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | task_10_frame_arbiter                                                      |
// | Round-robin, frame-at-a-time arbiter for the task 10 input buffer port.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module task_10_frame_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WORDS  = 243,
  parameter int LEN_W      = $clog2(MAX_WORDS + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_SRC-1:0]            i_src_tvalid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] i_src_tdata,
  input  logic [NUM_SRC-1:0]            i_src_tlast,
  output logic [NUM_SRC-1:0]            o_src_tready,
  output logic                          o_buf_tvalid,
  output logic [DATA_WIDTH-1:0]         o_buf_tdata,
  output logic                          o_buf_tlast,
  input  logic                          i_buf_tready,
  input  logic                          i_output_last,
  output logic [NUM_SRC-1:0]            o_grant,
  output logic                          o_busy,
  output logic                          o_frame_done,
  output logic [LEN_W-1:0]              o_frame_len,
  output logic                          o_overrun
);

  localparam int                IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [LEN_W-1:0]  C_LAST_CNT = LEN_W'(MAX_WORDS - 1);
  localparam logic [LEN_W-1:0]  C_MAX_LEN  = LEN_W'(MAX_WORDS);
  localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_XFER      = 2'd1,
    S_DRAIN     = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                  r_state, w_next;
  logic [IDX_W-1:0]        r_g, r_rr_ptr, w_pick, w_idx;
  logic                    w_found;
  logic [NUM_SRC-1:0]      r_grant;
  logic [LEN_W-1:0]        r_cnt, r_frame_len;
  logic                    r_frame_done, r_overrun;
  logic                    w_sel_valid, w_sel_last, w_acc, w_at_max;
  logic [DATA_WIDTH-1:0]   w_sel_data;

  assign w_sel_valid = i_src_tvalid[r_g];
  assign w_sel_last  = i_src_tlast[r_g];
  assign w_sel_data  = i_src_tdata[r_g*DATA_WIDTH +: DATA_WIDTH];
  assign w_at_max    = (r_cnt == C_LAST_CNT);
  assign w_acc       = w_sel_valid & (((r_state == S_XFER) & i_buf_tready) | (r_state == S_DRAIN));

  // First requester at or above the round-robin pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    w_idx   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_idx = IDX_W'((int'(r_rr_ptr) + i) % NUM_SRC);
      if (!w_found && i_src_tvalid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_src_tready = '0;
    o_buf_tvalid = 1'b0;
    o_buf_tlast  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_next = S_XFER;
      end
      S_XFER: begin
        o_src_tready[r_g] = i_buf_tready;
        // The buffer writes on valid alone, so valid must carry ready.
        o_buf_tvalid      = w_sel_valid & i_buf_tready;
        o_buf_tlast       = w_sel_last | w_at_max;
        if (w_acc) begin
          if (w_sel_last)    w_next = S_WAIT_DONE;
          else if (w_at_max) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_src_tready[r_g] = 1'b1;
        if (w_acc && w_sel_last) w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_output_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_g          <= '0;
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_cnt        <= '0;
      r_frame_len  <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_g     <= w_pick;
            r_grant <= {{(NUM_SRC-1){1'b0}}, 1'b1} << w_pick;
          end
        end
        S_XFER: begin
          if (w_acc) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_sel_last) begin
              r_frame_done <= 1'b1;
              r_frame_len  <= r_cnt + 1'b1;
            end else if (w_at_max) begin
              r_overrun   <= 1'b1;
              r_frame_len <= C_MAX_LEN;
            end
          end
        end
        S_DRAIN: begin
          if (w_acc && w_sel_last) r_frame_done <= 1'b1;
        end
        S_WAIT_DONE: begin
          if (i_output_last) begin
            r_rr_ptr <= (r_g == C_LAST_IDX) ? '0 : r_g + 1'b1;
            r_cnt    <= '0;
            r_grant  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_buf_tdata  = (r_state != S_IDLE) ? w_sel_data : '0;
  assign o_grant      = r_grant;
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = r_frame_done;
  assign o_frame_len  = r_frame_len;
  assign o_overrun    = r_overrun;

endmodule
`default_nettype wire
